// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the instruction-fetch front end.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DROP
    } fetch_state_e;

    localparam int unsigned PC_INC           = 4;
    localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: sequential +4 advance, branch redirect with word alignment,
// and a one-cycle misalignment flag for redirect targets.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] target,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] pc_plus4,
    output logic              misalign
);

    logic [AWIDTH-1:0] pc_reg;
    logic [AWIDTH-1:0] pc_next;
    logic              misalign_reg;

    // Wraps modulo 2^AWIDTH by construction.
    assign pc_plus4 = pc_reg + AWIDTH'(PC_INC);

    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = {target[AWIDTH-1:2], 2'b00};
        end else if (advance) begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg       <= BASEADDR;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= redirect && (target[1:0] != 2'b00);
        end
    end

    assign pc       = pc_reg;
    assign misalign = misalign_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, decode hand-off
// with stall hold, and redirect handling that discards stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              brtaken_i,
    input  logic [AWIDTH-1:0] target_i,
    input  logic              stall_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              insn_valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic              flush_o,
    output logic              misalign_o
);

    fetch_state_e      state_reg;
    fetch_state_e      state_next;
    logic [DWIDTH-1:0] insn_reg;
    logic [AWIDTH-1:0] pc_cur;
    logic [AWIDTH-1:0] pc_plus4;
    logic              in_out;
    logic              consume;
    logic              out_req;
    logic              req_fire;
    logic              capture;

    assign in_out   = (state_reg == OUT);
    assign consume  = in_out && !stall_i;
    // A redirect kills the presented instruction, so no prefetch leaves OUT that cycle.
    assign out_req  = consume && !brtaken_i;
    assign req_fire = imem_req_valid_o && imem_req_ready_i;

    fetch_pc_reg #(
        .AWIDTH  (AWIDTH),
        .BASEADDR(BASEADDR)
    ) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (consume),
        .redirect(brtaken_i),
        .target  (target_i),
        .pc      (pc_cur),
        .pc_plus4(pc_plus4),
        .misalign(misalign_o)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (brtaken_i) begin
                    state_next = req_fire ? DROP : REQ;
                end else if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (brtaken_i) begin
                        state_next = REQ;
                    end else begin
                        state_next = OUT;
                        capture    = 1'b1;
                    end
                end else if (brtaken_i) begin
                    state_next = DROP;
                end
            end
            OUT: begin
                if (brtaken_i) begin
                    state_next = REQ;
                end else if (!stall_i) begin
                    state_next = req_fire ? WAIT : REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            insn_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                insn_reg <= imem_rsp_data_i;
            end
        end
    end

    assign imem_req_valid_o = (state_reg == REQ) || out_req;
    assign imem_addr_o      = out_req ? pc_plus4 : pc_cur;
    assign insn_valid_o     = in_out;
    assign insn_o           = insn_reg;
    assign pc_o             = in_out ? pc_cur : '0;
    assign flush_o          = brtaken_i;

    // Responses are only legal while a request is outstanding.
    rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid_i |-> (state_reg == WAIT || state_reg == DROP));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// every cycle against an architectural model of the expected instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        brtaken_i;
    logic [31:0] target_i;
    logic        stall_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        insn_valid_o;
    logic [31:0] insn_o;
    logic [31:0] pc_o;
    logic        flush_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    fetch_unit #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .BASEADDR(BASE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .brtaken_i       (brtaken_i),
        .target_i        (target_i),
        .stall_i         (stall_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .insn_valid_o    (insn_valid_o),
        .insn_o          (insn_o),
        .pc_o            (pc_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instruction memory contents as a pure function of address.
    bit const_mode = 1'b1;
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (const_mode) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // imem responder knobs and state
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 never
    int          lat_min = 1;
    int          lat_max = 1;
    bit          over_next = 1'b0;
    bit          pend = 1'b0;
    bit          pend_over = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rsp_valid_i = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (acc_seen) begin
                pend      = 1'b1;
                cnt       = int'($urandom_range(lat_max, lat_min));
                pend_addr = acc_addr;
                pend_over = over_next;
                over_next = 1'b0;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = pend_over ? 32'hDEAD_BEEF : memf(pend_addr);
                    pend             = 1'b0;
                end
            end
        end
        case (ready_mode)
            0:       imem_req_ready_i = 1'b1;
            1:       imem_req_ready_i = (($urandom % 10) < 7);
            default: imem_req_ready_i = 1'b0;
        endcase
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!insn_valid_o && n < 40) begin
            tick();
            #2;
            n++;
        end
        chk(name, 32'(insn_valid_o), 32'd1);
    endtask

    // Architectural model: expected pc stream, outstanding/stale bookkeeping.
    logic [31:0] exp_pc = BASE;
    int          outstanding = 0;
    logic        out_stale = 1'b0;
    logic        present_due = 1'b0;
    logic        mis_exp = 1'b0;
    logic        p_valid = 1'b0, p_stall = 1'b0, p_br = 1'b0, p_req = 1'b0, p_ready = 1'b0;
    logic [31:0] p_addr = '0, p_insn = '0, p_pc = '0;
    int          consumed = 0;

    always @(negedge clk) begin
        logic hs, cons, exp_valid;
        if (!reset_n) begin
            chk("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
            chk("rst_insn_valid", 32'(insn_valid_o), 32'd0);
            chk("rst_addr", imem_addr_o, BASE);
            chk("rst_misalign", 32'(misalign_o), 32'd0);
            exp_pc = BASE; outstanding = 0; out_stale = 1'b0; present_due = 1'b0; mis_exp = 1'b0;
            p_valid = 1'b0; p_stall = 1'b0; p_br = 1'b0; p_req = 1'b0; p_ready = 1'b0;
            acc_seen = 1'b0;
        end else begin
            hs        = imem_req_valid_o && imem_req_ready_i;
            cons      = insn_valid_o && !stall_i && !brtaken_i;
            exp_valid = present_due || (p_valid && p_stall && !p_br);
            chk("flush", 32'(flush_o), 32'(brtaken_i));
            chk("misalign", 32'(misalign_o), 32'(mis_exp));
            chk("insn_valid", 32'(insn_valid_o), 32'(exp_valid));
            if (insn_valid_o) begin
                chk("pc", pc_o, exp_pc);
                chk("insn", insn_o, memf(exp_pc));
                if (!present_due) begin
                    chk("hold_insn", insn_o, p_insn);
                    chk("hold_pc", pc_o, p_pc);
                end
            end
            if (outstanding != 0) chk("single_outstanding", 32'(imem_req_valid_o), 32'd0);
            if (insn_valid_o && (stall_i || brtaken_i)) chk("no_req_from_out", 32'(imem_req_valid_o), 32'd0);
            if (p_req && !p_ready && !p_br) begin
                chk("req_held", 32'(imem_req_valid_o), 32'd1);
                chk("addr_held", imem_addr_o, p_addr);
            end
            if (hs && !brtaken_i) chk("req_addr", imem_addr_o, cons ? exp_pc + 32'd4 : exp_pc);

            if (cons) begin
                consumed++;
                $display("insn pc=%h data=%h", pc_o, insn_o);
            end
            if (imem_rsp_valid_i) outstanding--;
            present_due = imem_rsp_valid_i && !out_stale && !brtaken_i;
            if (brtaken_i) exp_pc = {target_i[31:2], 2'b00};
            else if (cons) exp_pc = exp_pc + 32'd4;
            if (hs) outstanding++;
            out_stale = (outstanding != 0) && (hs ? brtaken_i : (out_stale || brtaken_i));
            mis_exp   = brtaken_i && (target_i[1:0] != 2'b00);
            p_valid = insn_valid_o; p_stall = stall_i; p_br = brtaken_i;
            p_req = imem_req_valid_o; p_ready = imem_req_ready_i;
            p_addr = imem_addr_o; p_insn = insn_o; p_pc = pc_o;
            acc_seen = hs;
            acc_addr = imem_addr_o;
        end
    end

    initial begin
        reset_n = 1'b0; brtaken_i = 1'b0; target_i = '0; stall_i = 1'b0;
        imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        repeat (3) tick();
        #2;
        chk("reset_insn", insn_o, 32'd0);
        chk("reset_pc", pc_o, 32'd0);
        reset_n = 1'b1;                                      // cycle 0: IDLE

        // Zero-wait imem: 2 cycles per instruction, then a 5-cycle stall.
        tick(); #2;
        chk("first_req_valid", 32'(imem_req_valid_o), 32'd1);
        chk("first_req_addr", imem_addr_o, 32'h0100_0000);
        tick(); #2;
        chk("c2_no_insn", 32'(insn_valid_o), 32'd0);
        tick(); #2;
        chk("c3_valid", 32'(insn_valid_o), 32'd1);
        chk("c3_pc", pc_o, 32'h0100_0000);
        chk("c3_insn", insn_o, 32'h0000_0013);
        tick(); #2;
        tick(); #2;
        chk("c5_pc", pc_o, 32'h0100_0004);
        tick(); #2;
        chk("c6_no_insn", 32'(insn_valid_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); stall_i = 1'b1; #2;
            chk("stall_valid", 32'(insn_valid_o), 32'd1);
            chk("stall_pc", pc_o, 32'h0100_0008);
            chk("stall_noreq", 32'(imem_req_valid_o), 32'd0);
        end
        tick(); stall_i = 1'b0; lat_min = 3; lat_max = 3; over_next = 1'b1; #2;
        chk("unstall_req", 32'(imem_req_valid_o), 32'd1);
        chk("unstall_addr", imem_addr_o, 32'h0100_000C);

        // Redirect in WAIT with a late stale response.
        tick(); brtaken_i = 1'b1; target_i = 32'h0100_0040; #2;
        chk("wait_flush", 32'(flush_o), 32'd1);
        tick(); brtaken_i = 1'b0; lat_min = 1; lat_max = 1; #2;
        chk("drop_noreq", 32'(imem_req_valid_o), 32'd0);
        tick(); #2;
        chk("drop_rsp_noreq", 32'(imem_req_valid_o), 32'd0);
        tick(); #2;
        chk("redirect_req", 32'(imem_req_valid_o), 32'd1);
        chk("redirect_addr", imem_addr_o, 32'h0100_0040);

        // Redirect in the same cycle as the response.
        tick(); brtaken_i = 1'b1; target_i = 32'h0100_0080; #2;
        chk("rsp_br_flush", 32'(flush_o), 32'd1);
        tick(); brtaken_i = 1'b0; #2;
        chk("rsp_br_req", 32'(imem_req_valid_o), 32'd1);
        chk("rsp_br_addr", imem_addr_o, 32'h0100_0080);
        wait_valid("rsp_br_present");
        chk("rsp_br_pc", pc_o, 32'h0100_0080);

        // Misaligned redirect while stalled in OUT.
        stall_i = 1'b1; brtaken_i = 1'b1; target_i = 32'h0100_0102; #1;
        chk("out_br_noreq", 32'(imem_req_valid_o), 32'd0);
        tick(); stall_i = 1'b0; brtaken_i = 1'b0; #2;
        chk("out_br_killed", 32'(insn_valid_o), 32'd0);
        chk("out_br_misalign", 32'(misalign_o), 32'd1);
        chk("out_br_addr", imem_addr_o, 32'h0100_0100);
        tick(); #2;
        chk("misalign_once", 32'(misalign_o), 32'd0);

        // PC wrap and request backpressure.
        wait_valid("pre_wrap");
        brtaken_i = 1'b1; target_i = 32'hFFFF_FFFC; #1;
        tick(); brtaken_i = 1'b0; #2;
        chk("top_req_addr", imem_addr_o, 32'hFFFF_FFFC);
        wait_valid("top_present");
        chk("top_pc", pc_o, 32'hFFFF_FFFC);
        ready_mode = 2; imem_req_ready_i = 1'b0; #1;
        chk("wrap_addr", imem_addr_o, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("bp_req", 32'(imem_req_valid_o), 32'd1);
            chk("bp_addr", imem_addr_o, 32'h0000_0000);
        end
        ready_mode = 0;
        tick(); #2;
        wait_valid("wrap_present");
        chk("wrap_pc", pc_o, 32'h0000_0000);

        // Asynchronous reset in WAIT.
        lat_min = 3; lat_max = 3;
        tick(); #2;
        chk("pre_reset_wait", 32'(imem_req_valid_o), 32'd0);
        reset_n = 1'b0; #1;
        chk("async_req", 32'(imem_req_valid_o), 32'd0);
        chk("async_addr", imem_addr_o, BASE);
        chk("async_valid", 32'(insn_valid_o), 32'd0);
        chk("async_insn", insn_o, 32'd0);
        chk("async_pc", pc_o, 32'd0);
        const_mode = 1'b0; lat_min = 1; lat_max = 3;
        tick(); tick(); #2;
        reset_n = 1'b1;
        tick(); #2;
        chk("restart_addr", imem_addr_o, BASE);

        // Randomized traffic.
        ready_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall_i   = (($urandom % 4) == 0);
            brtaken_i = (($urandom % 14) == 0);
            case ($urandom % 3)
                0:       target_i = BASE + ($urandom % 1024);
                1:       target_i = 32'hFFFF_FFF0 + ($urandom % 16);
                default: target_i = $urandom;
            endcase
            #2;
        end
        brtaken_i = 1'b0; stall_i = 1'b0;
        tick(); #2;
        chk("liveness", 32'(consumed > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that consumes the execute stage's branch resolution (taken flag plus the ALU-computed target) and redirects the program counter. It issues one-outstanding-request fetches to instruction memory over a valid/ready request channel and a valid-only response channel. It presents fetched instructions to decode with a stall hold, and discards in-flight fetches made stale by a redirect. It sits between imem and the decode pipeline register.

Parameters:
AWIDTH, 32, address/PC width
DWIDTH, 32, instruction word width
BASEADDR, 32'h0100_0000, PC value after reset

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
brtaken_i  input  1  branch/jump taken, resolved in execute this cycle
target_i  input  AWIDTH  redirect target (ALU result) valid when brtaken_i=1
stall_i  input  1  decode cannot accept; hold presented instruction
imem_req_valid_o  output  1  fetch request valid
imem_req_ready_i  input  1  imem accepts request this cycle
imem_addr_o  output  AWIDTH  fetch address
imem_rsp_valid_i  input  1  response data valid (exactly one per accepted request, ≥1 cycle later)
imem_rsp_data_i  input  DWIDTH  fetched instruction
insn_valid_o  output  1  instruction presented to decode
insn_o  output  DWIDTH  presented instruction
pc_o  output  AWIDTH  PC of presented instruction
flush_o  output  1  kill younger pipeline stages (decode/IF-ID)
misalign_o  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc_q=BASEADDR, insn buffer=0; all outputs 0, imem_addr_o=BASEADDR.
- States: IDLE, REQ, WAIT, OUT, DROP.
- IDLE: no request; next cycle REQ. Exists only for the first cycle after reset release.
- REQ: imem_req_valid_o=1, imem_addr_o=pc_q. On imem_req_ready_i go to WAIT, else stay. valid/addr are held stable until accepted.
- WAIT: on imem_rsp_valid_i, capture data into insn buffer and go to OUT.
- OUT: insn_valid_o=1, insn_o=buffer, pc_o=pc_q.
  - If stall_i=1: hold all outputs, no request.
  - If stall_i=0: instruction consumed this cycle, pc_q<=pc_q+4.
  - Also in OUT with stall_i=0, imem_req_valid_o=1 with imem_addr_o=pc_q+4. On ready go to WAIT, else REQ.
  - Throughput: 2 cycles per instruction with a zero-wait imem (REQ→WAIT→OUT initially, then OUT↔WAIT).
- PC arithmetic: modulo 2^AWIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect (brtaken_i=1), highest priority, overrides stall_i and normal transitions:
  - flush_o=brtaken_i, combinational, same cycle.
  - pc_q<={target_i[AWIDTH-1:2],2'b00}. misalign_o=1 next cycle if target_i[1:0]!=0.
  - In OUT the presented instruction is killed: insn_valid_o goes low next cycle, the consume is ignored, and no request from OUT is issued that cycle (imem_req_valid_o forced 0).
  - Next state by current state and same-cycle events:
    - REQ with no handshake this cycle: REQ.
    - REQ with handshake this cycle (request now stale): DROP.
    - WAIT with no response this cycle: DROP.
    - WAIT with response this cycle: response discarded, go to REQ.
    - OUT: REQ.
    - DROP with no response this cycle: DROP, pc updated.
    - DROP with response this cycle: REQ, pc updated.
- DROP: no request, insn_valid_o=0. On imem_rsp_valid_i, discard the response and go to REQ with the current pc_q.
- Single outstanding request invariant: imem_req_valid_o never 1 in WAIT or DROP.
- imem_rsp_valid_i in IDLE/REQ/OUT is a protocol error: ignored; a simulation assertion must fire.
- Async reset mid-transaction returns to IDLE immediately. Any later orphan response is covered by the error rule above; imem is reset by the same reset_n.

Decomposition:
- Shared package (pipeline types): fetch_state_e enum {IDLE,REQ,WAIT,OUT,DROP}, PC increment constant (4), BASEADDR default.
- One natural sub-module: fetch_pc_reg, holding the PC register, +4 adder and redirect mux with target alignment and misalign detect. The FSM and insn buffer stay in the top module.

Test Plan:
- Reset release, imem always ready with 1-cycle response returning 32'h0000_0013 → first request addr 32'h0100_0000; insn_valid_o at cycle 3; pc_o sequence 0100_0000, 0100_0004, 0100_0008 every 2 cycles.
- stall_i=1 for 5 cycles while in OUT at pc 0100_0008 → insn_o/pc_o held constant, imem_req_valid_o=0 throughout; fetch of 0100_000C issued the cycle stall drops.
- brtaken_i=1, target_i=32'h0100_0040 while in WAIT with no response → flush_o=1 same cycle; late response (data DEADBEEF) dropped, never presented; next request addr 0100_0040.
- brtaken_i in same cycle as imem_rsp_valid_i in WAIT → response discarded, no DROP cycle, request to target next cycle.
- brtaken_i in OUT with stall_i=1, target_i=32'h0100_0102 → insn_valid_o low next cycle, misalign_o pulses once, next request addr 0100_0100.
- imem_req_ready_i low 3 cycles in REQ; pc_q at 32'hFFFF_FFFC consumed → addr stable during backpressure; next fetch addr wraps to 0; assert reset_n mid-WAIT → all outputs 0 immediately, restart at BASEADDR.
